// File: rtl/nv_nvdla_cvt_pkg.sv
// Shared widths, stage payload structs and sign-extension helpers for the
// convertor scale pipe (nv_nvdla_cvt_scale_pipe).
// Optional feature macro: NVDLA_CVT_BYPASS_EN adds a bypass bit to the S1 payload.
package nv_nvdla_cvt_pkg;

    localparam int unsigned IN_WIDTH    = 32;
    localparam int unsigned SCALE_WIDTH = 16;
    localparam int unsigned SHIFT_WIDTH = 6;
    localparam int unsigned SUB_WIDTH   = IN_WIDTH + 1;
    localparam int unsigned OUT_WIDTH   = SUB_WIDTH + SCALE_WIDTH;

    // Payload held by stage 1: offset-subtracted element plus its own config
    typedef struct packed {
        logic [SUB_WIDTH-1:0]   sub;
        logic [SCALE_WIDTH-1:0] scale;
        logic [SHIFT_WIDTH-1:0] truncate;
`ifdef NVDLA_CVT_BYPASS_EN
        logic                   bypass;
`endif
    } cvt_s1_pay_t;

    // Payload held by stage 2: final product and aligned shift amount
    typedef struct packed {
        logic [OUT_WIDTH-1:0]   prod;
        logic [SHIFT_WIDTH-1:0] truncate;
    } cvt_s2_pay_t;

    // Sign-extend an input-width value by one bit so the subtract is exact
    function automatic logic [SUB_WIDTH-1:0] sext_in_to_sub(input logic [IN_WIDTH-1:0] x);
        return {x[IN_WIDTH-1], x};
    endfunction

    // Sign-extend the subtract result to the full product width
    function automatic logic [OUT_WIDTH-1:0] sext_sub_to_out(input logic [SUB_WIDTH-1:0] x);
        return {{SCALE_WIDTH{x[SUB_WIDTH-1]}}, x};
    endfunction

    // Signed multiply: both operands sign-extended to OUT_WIDTH; the low
    // OUT_WIDTH bits of the two's complement product are exact.
    function automatic logic [OUT_WIDTH-1:0] smul(input logic [SUB_WIDTH-1:0]   a,
                                                  input logic [SCALE_WIDTH-1:0] b);
        logic [OUT_WIDTH-1:0] a_ext;
        logic [OUT_WIDTH-1:0] b_ext;
        a_ext = {{SCALE_WIDTH{a[SUB_WIDTH-1]}}, a};
        b_ext = {{SUB_WIDTH{b[SCALE_WIDTH-1]}}, b};
        return OUT_WIDTH'(a_ext * b_ext);
    endfunction

endpackage

// File: rtl/nv_nvdla_cvt_pipe_stage.sv
// Generic one-entry valid/ready register slice.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_vld / in_rdy_c   upstream handshake (in_rdy_c is combinational)
//   in_data             payload loaded on an upstream transfer
//   out_vld / out_rdy   downstream handshake (out_vld registered)
//   out_data            registered payload
module nv_nvdla_cvt_pipe_stage #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy_c,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data
);

    logic load_c;

    // Accept when empty or when the held entry drains this cycle
    assign in_rdy_c = ~out_vld | out_rdy;
    assign load_c   = in_vld & in_rdy_c;

    // Valid: reloads from upstream whenever the slot frees, else holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
        end else if (in_rdy_c) begin
            out_vld <= in_vld;
        end
    end

    // Payload only toggles on an actual transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (load_c) begin
            out_data <= in_data;
        end
    end

endmodule

// File: rtl/nv_nvdla_cvt_scale_pipe.sv
// Two-stage convertor pipe: out = (data - offset) * scale, with the per-element
// truncate amount carried alongside for the downstream saturating shifter.
// Config is captured with each element, so in-flight data is never affected.
// Optional feature macro: NVDLA_CVT_BYPASS_EN (adds cfg_bypass; bypassed
// elements leave as sext(data) with shift 0, same latency).
// Ports:
//   nvdla_core_clk, nvdla_core_rst   clock, asynchronous active-high reset
//   cvt_in_pvld/prdy/data            input element handshake and data
//   cfg_offset/scale/truncate        per-element config, sampled on accept
//   cfg_bypass                       bypass select (NVDLA_CVT_BYPASS_EN only)
//   cvt_out_pvld/prdy/data/shift     output product handshake and shift amount
//   cvt_idle                         both stages empty
module nv_nvdla_cvt_scale_pipe
    import nv_nvdla_cvt_pkg::*;
(
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rst,
    input  logic                   cvt_in_pvld,
    output logic                   cvt_in_prdy,
    input  logic [IN_WIDTH-1:0]    cvt_in_data,
    input  logic [IN_WIDTH-1:0]    cfg_offset,
    input  logic [SCALE_WIDTH-1:0] cfg_scale,
    input  logic [SHIFT_WIDTH-1:0] cfg_truncate,
`ifdef NVDLA_CVT_BYPASS_EN
    input  logic                   cfg_bypass,
`endif
    output logic                   cvt_out_pvld,
    input  logic                   cvt_out_prdy,
    output logic [OUT_WIDTH-1:0]   cvt_out_data,
    output logic [SHIFT_WIDTH-1:0] cvt_out_shift,
    output logic                   cvt_idle
);

    cvt_s1_pay_t s1_in_c;
    cvt_s1_pay_t s1_q;
    cvt_s2_pay_t s2_in_c;
    cvt_s2_pay_t s2_q;
    logic        s1_vld;
    logic        s2_rdy_c;

    // S1 datapath: exact offset subtract; bypassed elements skip the offset
    always_comb begin
        s1_in_c          = '0;
        s1_in_c.sub      = sext_in_to_sub(cvt_in_data) - sext_in_to_sub(cfg_offset);
        s1_in_c.scale    = cfg_scale;
        s1_in_c.truncate = cfg_truncate;
`ifdef NVDLA_CVT_BYPASS_EN
        s1_in_c.bypass   = cfg_bypass;
        if (cfg_bypass) begin
            s1_in_c.sub = sext_in_to_sub(cvt_in_data);
        end
`endif
    end

    nv_nvdla_cvt_pipe_stage #(
        .WIDTH ($bits(cvt_s1_pay_t))
    ) u_s1 (
        .clk      (nvdla_core_clk),
        .rst      (nvdla_core_rst),
        .in_vld   (cvt_in_pvld),
        .in_rdy_c (cvt_in_prdy),
        .in_data  (s1_in_c),
        .out_vld  (s1_vld),
        .out_rdy  (s2_rdy_c),
        .out_data (s1_q)
    );

    // S2 datapath: exact signed product; bypass passes the element through
    always_comb begin
        s2_in_c          = '0;
        s2_in_c.prod     = smul(s1_q.sub, s1_q.scale);
        s2_in_c.truncate = s1_q.truncate;
`ifdef NVDLA_CVT_BYPASS_EN
        if (s1_q.bypass) begin
            s2_in_c.prod     = sext_sub_to_out(s1_q.sub);
            s2_in_c.truncate = '0;
        end
`endif
    end

    nv_nvdla_cvt_pipe_stage #(
        .WIDTH ($bits(cvt_s2_pay_t))
    ) u_s2 (
        .clk      (nvdla_core_clk),
        .rst      (nvdla_core_rst),
        .in_vld   (s1_vld),
        .in_rdy_c (s2_rdy_c),
        .in_data  (s2_in_c),
        .out_vld  (cvt_out_pvld),
        .out_rdy  (cvt_out_prdy),
        .out_data (s2_q)
    );

    assign cvt_out_data  = s2_q.prod;
    assign cvt_out_shift = s2_q.truncate;
    assign cvt_idle      = ~s1_vld & ~cvt_out_pvld;

endmodule

// File: tb/tb_nv_nvdla_cvt_scale_pipe.sv
// Self-checking bench for nv_nvdla_cvt_scale_pipe: scenario tasks plus a
// scoreboard that predicts each accepted element and checks it on output.
module tb_nv_nvdla_cvt_scale_pipe;

    logic        clk;
    logic        rst;
    logic        in_pvld;
    logic        in_prdy;
    logic [31:0] in_data;
    logic [31:0] cfg_offset;
    logic [15:0] cfg_scale;
    logic [5:0]  cfg_truncate;
    logic        cfg_bypass;
    logic        out_pvld;
    logic        out_prdy;
    logic [48:0] out_data;
    logic [5:0]  out_shift;
    logic        idle;

    int n_checks = 0;
    int n_fail   = 0;
    int n_in     = 0;
    int n_out    = 0;

    typedef struct {
        logic [48:0] d;
        logic [5:0]  s;
    } exp_t;

    exp_t sb[$];

    nv_nvdla_cvt_scale_pipe dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .cvt_in_pvld    (in_pvld),
        .cvt_in_prdy    (in_prdy),
        .cvt_in_data    (in_data),
        .cfg_offset     (cfg_offset),
        .cfg_scale      (cfg_scale),
        .cfg_truncate   (cfg_truncate),
`ifdef NVDLA_CVT_BYPASS_EN
        .cfg_bypass     (cfg_bypass),
`endif
        .cvt_out_pvld   (out_pvld),
        .cvt_out_prdy   (out_prdy),
        .cvt_out_data   (out_data),
        .cvt_out_shift  (out_shift),
        .cvt_idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model of one element
    function automatic exp_t model(input logic [31:0] d, input logic [31:0] o,
                                   input logic [15:0] sc, input logic [5:0] tr,
                                   input logic byp);
        longint sd, so, ss, p;
        exp_t   e;
        sd = longint'($signed(d));
        so = longint'($signed(o));
        ss = longint'($signed(sc));
        if (byp) begin
            p   = sd;
            e.s = 6'd0;
        end else begin
            p   = (sd - so) * ss;
            e.s = tr;
        end
        e.d = p[48:0];
        return e;
    endfunction

    // Scoreboard: pop on output transfer, push on input transfer
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_pvld && out_prdy) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: out_data=%h with no element expected", out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.d || out_shift !== e.s) begin
                        n_fail++;
                        $display("FAIL sb_data: got data=%h shift=%h expected data=%h shift=%h",
                                 out_data, out_shift, e.d, e.s);
                    end
                end
                n_out++;
            end
            if (in_pvld && in_prdy) begin
                sb.push_back(model(in_data, cfg_offset, cfg_scale, cfg_truncate, cfg_bypass));
                n_in++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one element and hold it until accepted; returns just after the accepting edge
    task automatic send(input logic [31:0] d, input logic [31:0] o, input logic [15:0] sc,
                        input logic [5:0] tr, input logic byp);
        int n = 0;
        in_data      = d;
        cfg_offset   = o;
        cfg_scale    = sc;
        cfg_truncate = tr;
        cfg_bypass   = byp;
        in_pvld      = 1'b1;
        @(negedge clk);
        while (!in_prdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_prdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_prdy=%b expected 1 within 50 cycles", in_prdy);
        end
        step();
    endtask

    task automatic wait_out();
        int n = 0;
        @(negedge clk);
        while (!out_pvld && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!out_pvld) begin
            n_fail++;
            $display("FAIL out_timeout: out_pvld=%b expected 1 within 20 cycles", out_pvld);
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d elements outstanding, expected 0", sb.size());
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_pvld = 1'b0; out_prdy = 1'b1;
        in_data = '0; cfg_offset = '0; cfg_scale = '0; cfg_truncate = '0; cfg_bypass = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks += 5;
        if (out_pvld !== 1'b0) begin n_fail++; $display("FAIL rst_out_pvld: got %b expected 0", out_pvld); end
        if (in_prdy !== 1'b1) begin n_fail++; $display("FAIL rst_in_prdy: got %b expected 1", in_prdy); end
        if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b expected 1", idle); end
        if (out_data !== 49'd0) begin n_fail++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
        if (out_shift !== 6'd0) begin n_fail++; $display("FAIL rst_out_shift: got %h expected 0", out_shift); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        out_prdy = 1'b1;
        send(32'd100, 32'd20, 16'd3, 6'd4, 1'b0);
        in_pvld = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (out_pvld !== 1'b0) begin n_fail++; $display("FAIL basic_lat1_pvld: got %b expected 0", out_pvld); end
        if (idle !== 1'b0) begin n_fail++; $display("FAIL basic_busy_idle: got %b expected 0", idle); end
        step();
        @(negedge clk);
        n_checks += 3;
        if (out_pvld !== 1'b1) begin n_fail++; $display("FAIL basic_lat2_pvld: got %b expected 1", out_pvld); end
        if (out_data !== 49'd240) begin n_fail++; $display("FAIL basic_data: got %0d expected 240", out_data); end
        if (out_shift !== 6'd4) begin n_fail++; $display("FAIL basic_shift: got %0d expected 4", out_shift); end
        step();
        @(negedge clk);
        n_checks += 2;
        if (out_pvld !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got %b expected 0", out_pvld); end
        if (idle !== 1'b1) begin n_fail++; $display("FAIL basic_idle: got %b expected 1", idle); end
        step();
    endtask

    task automatic test_extremes();
        out_prdy = 1'b1;
        send(32'h8000_0000, 32'h7FFF_FFFF, 16'h8000, 6'd0, 1'b0);
        in_pvld = 1'b0;
        wait_out();
        n_checks++;
        if (out_data !== 49'h0_7FFF_FFFF_8000) begin
            n_fail++;
            $display("FAIL extremes_data: got %h expected 07fffffff8000", out_data);
        end
        wait_empty();
    endtask

    task automatic set_elem(input int k);
        in_data      = 32'(1000 + k * 7);
        cfg_offset   = 32'(k);
        cfg_scale    = 16'(k + 2);
        cfg_truncate = 6'(k);
        cfg_bypass   = 1'b0;
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int in0, out0;
        in0 = n_in; out0 = n_out;
        out_prdy = 1'b0;
        set_elem(0);
        in_pvld = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (in_prdy) acc++;
            step();
            set_elem(acc);
        end
        @(negedge clk);
        n_checks += 3;
        if (acc != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 2", acc); end
        if (in_prdy !== 1'b0) begin n_fail++; $display("FAIL bp_in_prdy: got %b expected 0", in_prdy); end
        if (out_pvld !== 1'b1) begin n_fail++; $display("FAIL bp_out_hold: got %b expected 1", out_pvld); end
        step();
        out_prdy = 1'b1;
        for (int k = acc; k < 5; k++) begin
            send(32'(1000 + k * 7), 32'(k), 16'(k + 2), 6'(k), 1'b0);
        end
        in_pvld = 1'b0;
        wait_empty();
        n_checks += 2;
        if (n_in - in0 != 5) begin n_fail++; $display("FAIL bp_in_count: got %0d expected 5", n_in - in0); end
        if (n_out - out0 != 5) begin n_fail++; $display("FAIL bp_out_count: got %0d expected 5", n_out - out0); end
    endtask

    task automatic test_config_change();
        out_prdy = 1'b1;
        send(32'd10, 32'd0, 16'd2, 6'd1, 1'b0);
        send(32'd10, 32'd0, 16'd5, 6'd1, 1'b0);
        in_pvld = 1'b0;
        wait_out();
        n_checks++;
        if (out_data !== 49'd20) begin n_fail++; $display("FAIL cfg_a_data: got %0d expected 20", out_data); end
        step();
        @(negedge clk);
        n_checks += 2;
        if (out_pvld !== 1'b1) begin n_fail++; $display("FAIL cfg_b_pvld: got %b expected 1", out_pvld); end
        if (out_data !== 49'd50) begin n_fail++; $display("FAIL cfg_b_data: got %0d expected 50", out_data); end
        wait_empty();
    endtask

    task automatic test_reset_midstream();
        out_prdy = 1'b0;
        send(32'd7, 32'd1, 16'd3, 6'd2, 1'b0);
        send(32'd8, 32'd1, 16'd3, 6'd2, 1'b0);
        in_pvld = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (in_prdy !== 1'b0) begin n_fail++; $display("FAIL mid_full_prdy: got %b expected 0", in_prdy); end
        if (idle !== 1'b0) begin n_fail++; $display("FAIL mid_full_idle: got %b expected 0", idle); end
        step();
        rst = 1'b1;
        #1;
        n_checks += 3;
        if (out_pvld !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pvld: got %b expected 0", out_pvld); end
        if (idle !== 1'b1) begin n_fail++; $display("FAIL mid_rst_idle: got %b expected 1", idle); end
        if (in_prdy !== 1'b1) begin n_fail++; $display("FAIL mid_rst_prdy: got %b expected 1", in_prdy); end
        step();
        rst = 1'b0;
        out_prdy = 1'b1;
        step();
        send(32'd50, 32'd10, 16'hFFFE, 6'd5, 1'b0);
        in_pvld = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_pvld !== 1'b0) begin n_fail++; $display("FAIL mid_new_lat1: got %b expected 0", out_pvld); end
        step();
        @(negedge clk);
        n_checks += 3;
        if (out_pvld !== 1'b1) begin n_fail++; $display("FAIL mid_new_lat2: got %b expected 1", out_pvld); end
        if (out_data !== 49'h1_FFFF_FFFF_FFB0) begin n_fail++; $display("FAIL mid_new_data: got %h expected 1ffffffffffb0", out_data); end
        if (out_shift !== 6'd5) begin n_fail++; $display("FAIL mid_new_shift: got %0d expected 5", out_shift); end
        wait_empty();
    endtask

`ifdef NVDLA_CVT_BYPASS_EN
    task automatic test_bypass();
        out_prdy = 1'b1;
        send(32'hFFFF_FFFB, 32'd100, 16'd7, 6'd3, 1'b1);
        in_pvld = 1'b0;
        cfg_bypass = 1'b0;
        wait_out();
        n_checks += 2;
        if (out_data !== 49'h1_FFFF_FFFF_FFFB) begin n_fail++; $display("FAIL byp_data: got %h expected 1fffffffffffb", out_data); end
        if (out_shift !== 6'd0) begin n_fail++; $display("FAIL byp_shift: got %0d expected 0", out_shift); end
        wait_empty();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_config_change();
        test_reset_midstream();
`ifdef NVDLA_CVT_BYPASS_EN
        test_bypass();
`endif
        repeat (3) step();
        n_checks += 2;
        if (sb.size() != 0) begin n_fail++; $display("FAIL final_sb: %0d left expected 0", sb.size()); end
        if (idle !== 1'b1) begin n_fail++; $display("FAIL final_idle: got %b expected 1", idle); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
